// File: rtl/result_deskew_buffer_if.sv
// Handshake/data bundle between the systolic array, the deskew buffer and writeback.
// master drives capture inputs and out_ready; slave is the deskew buffer itself.
interface result_deskew_buffer_if #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int SH_W  = 5
);
  logic                 start;
  logic                 in_en;
  logic [N*ACC_W-1:0]   in_data;
  logic                 transpose;
  logic [SH_W-1:0]      requant_shift;
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*OUT_W-1:0]   out_data;
  logic                 out_last;
  logic                 sat_flag;

  modport master (
    output start, in_en, in_data, transpose, requant_shift, out_ready,
    input  busy, out_valid, out_data, out_last, sat_flag
  );

  modport slave (
    input  start, in_en, in_data, transpose, requant_shift, out_ready,
    output busy, out_valid, out_data, out_last, sat_flag
  );
endinterface

// File: rtl/result_deskew_buffer.sv
// Captures the diagonally skewed systolic result stream into an NxN tile,
// requantises each element (shift + saturate) and drains it by row or column.
//
// state   | meaning
// IDLE    | waiting for start; the start cycle itself is capture step 0
// CAPTURE | taking skewed steps t = 1 .. 2N-2 on in_en
// DRAIN   | presenting one row/column per valid/ready beat
module result_deskew_buffer #(
  parameter int N     = 4,
  parameter int ACC_W = 32,
  parameter int OUT_W = 8,
  parameter int SH_W  = 5
) (
  input logic                    clk,
  input logic                    reset_n,
  result_deskew_buffer_if.slave  bus
);
  localparam int TW = $clog2(2*N-1);
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(2*N-2);
  localparam logic [BW-1:0] B_LAST = BW'(N-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t            state;
  logic [TW-1:0]     t;
  logic [BW-1:0]     b;
  logic [SH_W-1:0]   shift_q;
  logic              transpose_q;
  logic              sat_q;
  logic              busy_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic signed [OUT_W-1:0] tile [N][N];

  logic                    cap_fire;
  logic [TW-1:0]           t_cur;
  logic [SH_W-1:0]         shift_cur;
  logic [N-1:0]            lane_win;
  logic [N-1:0]            lane_sat;
  logic [BW-1:0]           lane_row [N];
  logic signed [ACC_W-1:0] shifted  [N];
  logic signed [OUT_W-1:0] lane_q   [N];
  logic                    any_sat;

  // Step 0 lands on the start cycle, before shift/step are latched, so use live values there.
  always_comb begin
    t_cur     = (state == IDLE) ? '0 : t;
    shift_cur = (state == IDLE) ? bus.requant_shift : shift_q;
    cap_fire  = bus.in_en && ((state == IDLE && bus.start) || state == CAPTURE);
    for (int k = 0; k < N; k++) begin
      shifted[k]  = $signed(bus.in_data[k*ACC_W +: ACC_W]) >>> shift_cur;
      lane_win[k] = (int'(t_cur) >= k) && (int'(t_cur) - k <= N-1);
      lane_row[k] = BW'(int'(t_cur) - k);
      lane_sat[k] = 1'b0;
      if (shifted[k] > SAT_MAX) begin
        lane_q[k]   = SAT_MAX[OUT_W-1:0];
        lane_sat[k] = 1'b1;
      end else if (shifted[k] < SAT_MIN) begin
        lane_q[k]   = SAT_MIN[OUT_W-1:0];
        lane_sat[k] = 1'b1;
      end else begin
        lane_q[k]   = shifted[k][OUT_W-1:0];
      end
    end
    any_sat = |(lane_win & lane_sat);
  end

  // Tile storage has no reset; a fresh tile fully overwrites it before any drain.
  always_ff @(posedge clk) begin
    if (reset_n && cap_fire) begin
      for (int k = 0; k < N; k++) begin
        if (lane_win[k]) tile[lane_row[k]][k] <= lane_q[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      t           <= '0;
      b           <= '0;
      shift_q     <= '0;
      transpose_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= CAPTURE;
            shift_q     <= bus.requant_shift;
            transpose_q <= bus.transpose;
            sat_q       <= cap_fire && any_sat;
            busy_q      <= 1'b1;
            b           <= '0;
            t           <= bus.in_en ? TW'(1) : '0;
          end
        end
        CAPTURE: begin
          if (bus.in_en) begin
            sat_q <= sat_q | any_sat;
            if (t == T_LAST) begin
              state       <= DRAIN;
              out_valid_q <= 1'b1;
              out_last_q  <= (B_LAST == '0);
              b           <= '0;
            end else begin
              t <= t + TW'(1);
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            if (b == B_LAST) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              b           <= '0;
              t           <= '0;
            end else begin
              b          <= b + BW'(1);
              out_last_q <= (b + BW'(1) == B_LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_data = '0;
    for (int j = 0; j < N; j++) begin
      if (out_valid_q)
        bus.out_data[j*OUT_W +: OUT_W] = transpose_q ? tile[j][b] : tile[b][j];
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.sat_flag  = sat_q;
endmodule

// File: tb/tb_result_deskew_buffer.sv
// Directed bench for result_deskew_buffer: skewed capture, requant, transpose,
// stalls, abort by reset and ignored start pulses.
module tb_result_deskew_buffer;
  localparam int N = 4, ACC_W = 32, OUT_W = 8, SH_W = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  result_deskew_buffer_if #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) bus ();
  result_deskew_buffer #(.N(N), .ACC_W(ACC_W), .OUT_W(OUT_W), .SH_W(SH_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int total = 0, passed = 0, cyc = 0;
  int src_m [N][N];
  int exp_m [N][N];
  bit exp_sat;
  int ready_pat [8];

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [N*ACC_W-1:0] lanes(input int t);
    logic [N*ACC_W-1:0] l;
    for (int k = 0; k < N; k++) begin
      if (t - k >= 0 && t - k < N) l[k*ACC_W +: ACC_W] = ACC_W'(src_m[t-k][k]);
      else                         l[k*ACC_W +: ACC_W] = 32'h7fff_0000;
    end
    return l;
  endfunction

  task automatic set_identity();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin src_m[r][c] = 10*r + c; exp_m[r][c] = 10*r + c; end
  endtask

  task automatic fill(input int v, input int e);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin src_m[r][c] = v; exp_m[r][c] = e; end
  endtask

  task automatic capture(input bit tr, input logic [SH_W-1:0] sh, input bit stall, input bit pulse);
    int t0;
    t0 = cyc;
    bus.start = 1'b1; bus.transpose = tr; bus.requant_shift = sh;
    for (int t = 0; t < 2*N-1; t++) begin
      if (stall && t == 3) begin
        bus.in_en = 1'b0; bus.in_data = {N{32'h7fff_0000}};
        repeat (3) tick();
      end
      bus.in_en = 1'b1; bus.in_data = lanes(t);
      if (pulse && t == 3) begin bus.start = 1'b1; bus.transpose = ~tr; bus.requant_shift = 5'd7; end
      if (t > 0) begin
        check("cap_busy", bus.busy, 1);
        check("cap_valid", bus.out_valid, 0);
      end
      tick();
      bus.start = 1'b0; bus.transpose = tr; bus.requant_shift = sh;
    end
    bus.in_en = 1'b0;
    check("latency", cyc - t0, stall ? 10 : 7);
    check("drain_entry_valid", bus.out_valid, 1);
  endtask

  task automatic drain(input bit tr, input bit use_pat, input bit pulse_last);
    int b, hs;
    logic [N*OUT_W-1:0] e;
    b = 0; hs = 0;
    for (int i = 0; i < 40 && hs < N; i++) begin
      bus.out_ready = use_pat ? ready_pat[i % 8][0] : 1'b1;
      for (int j = 0; j < N; j++) e[j*OUT_W +: OUT_W] = OUT_W'(tr ? exp_m[j][b] : exp_m[b][j]);
      check("drain_valid", bus.out_valid, 1);
      check("drain_data", bus.out_data, e);
      check("drain_last", bus.out_last, (b == N-1));
      check("drain_sat", bus.sat_flag, exp_sat);
      if (pulse_last && b == N-1 && bus.out_ready) bus.start = 1'b1;
      if (bus.out_valid && bus.out_ready) begin hs++; b++; end
      tick();
      bus.start = 1'b0;
    end
    bus.out_ready = 1'b0;
    check("handshakes", hs, N);
    check("end_valid", bus.out_valid, 0);
    check("end_busy", bus.busy, 0);
    check("end_last", bus.out_last, 0);
    tick();
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    ready_pat = '{1, 0, 0, 1, 1, 1, 1, 1};
    bus.start = 0; bus.in_en = 0; bus.in_data = '0; bus.transpose = 0;
    bus.requant_shift = '0; bus.out_ready = 0;
    reset_n = 1'b0;
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.out_valid, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_sat", bus.sat_flag, 0);
    check("rst_data", bus.out_data, 0);
    reset_n = 1'b1;
    tick();

    set_identity(); exp_sat = 0;
    capture(0, 5'd0, 0, 0); drain(0, 0, 0);

    // start pulses mid-capture (with altered config) and on the last handshake must be ignored
    capture(1, 5'd0, 0, 1); drain(1, 0, 1);

    fill(1000, 127);   exp_sat = 1; capture(0, 5'd2, 0, 0);  drain(0, 0, 0);
    fill(-1000, -128); exp_sat = 1; capture(0, 5'd2, 0, 0);  drain(0, 0, 0);
    fill(400, 100);    exp_sat = 0; capture(0, 5'd2, 0, 0);  drain(0, 0, 0);
    fill(-5, -3);      exp_sat = 0; capture(1, 5'd1, 0, 0);  drain(1, 0, 0);
    fill(-1000, -1);   exp_sat = 0; capture(0, 5'd31, 0, 0); drain(0, 0, 0);
    fill(1000, 0);     exp_sat = 0; capture(0, 5'd31, 0, 0); drain(0, 0, 0);

    set_identity(); exp_sat = 0;
    capture(0, 5'd0, 1, 0); drain(0, 1, 0);

    fill(77, 77);
    bus.start = 1'b1; bus.transpose = 0; bus.requant_shift = '0;
    for (int t = 0; t < 3; t++) begin
      bus.in_en = 1'b1; bus.in_data = lanes(t);
      tick();
      bus.start = 1'b0;
    end
    reset_n = 1'b0; bus.in_en = 1'b1; bus.in_data = lanes(3);
    tick();
    reset_n = 1'b1; bus.in_en = 1'b0;
    check("abort_valid", bus.out_valid, 0);
    check("abort_busy", bus.busy, 0);
    repeat (3) begin
      tick();
      check("abort_quiet", bus.out_valid, 0);
    end
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin src_m[r][c] = 5*r - 3*c; exp_m[r][c] = 5*r - 3*c; end
    exp_sat = 0;
    capture(0, 5'd0, 0, 0); drain(0, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
